// File: rtl/shift_pkg.sv
// Shared constants and decode payload for the shift issue stage and ALU decoder.
package shift_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 2;

  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] FUNCT_SRA  = 6'b000011;
  localparam logic [FUNCT_W-1:0] FUNCT_SLLV = 6'b000100;
  localparam logic [FUNCT_W-1:0] FUNCT_SRLV = 6'b000110;
  localparam logic [FUNCT_W-1:0] FUNCT_SRAV = 6'b000111;

  localparam logic [ALU_W-1:0] ALU_NOP = 2'b00;
  localparam logic [ALU_W-1:0] ALU_SRL = 2'b01;
  localparam logic [ALU_W-1:0] ALU_SRA = 2'b10;
  localparam logic [ALU_W-1:0] ALU_SLL = 2'b11;

  // Decoded shift control: shifter op, amount, and illegal-funct flag.
  typedef struct packed {
    logic [ALU_W-1:0]   alu;
    logic [SHAMT_W-1:0] amt;
    logic               err;
  } dec_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational funct decode: selects shifter op and immediate/register shift amount.
module shift_decode
  import shift_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [SHAMT_W-1:0] rs_amt_i,
  output dec_t               dec_c_o
);

  always_comb begin
    dec_c_o = '{alu: ALU_NOP, amt: '0, err: 1'b1};
    case (funct_i)
      FUNCT_SLL:  dec_c_o = '{alu: ALU_SLL, amt: shamt_i,  err: 1'b0};
      FUNCT_SRL:  dec_c_o = '{alu: ALU_SRL, amt: shamt_i,  err: 1'b0};
      FUNCT_SRA:  dec_c_o = '{alu: ALU_SRA, amt: shamt_i,  err: 1'b0};
      FUNCT_SLLV: dec_c_o = '{alu: ALU_SLL, amt: rs_amt_i, err: 1'b0};
      FUNCT_SRLV: dec_c_o = '{alu: ALU_SRL, amt: rs_amt_i, err: 1'b0};
      FUNCT_SRAV: dec_c_o = '{alu: ALU_SRA, amt: rs_amt_i, err: 1'b0};
      default:    ;
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Two-stage valid/ready issue stage around an external barrel shifter.
// Optional counters stat_ops/stat_err exist only when SHIFT_ISSUE_STAT_EN is defined.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FUNCT_W-1:0]   in_funct,
  input  logic [DATA_W-1:0]    in_rt,
  input  logic [DATA_W-1:0]    in_rs,
  input  logic [SHAMT_W-1:0]   in_shamt,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [DATA_W-1:0]    sh_a,
  output logic [SHAMT_W-1:0]   sh_b,
  output logic [ALU_W-1:0]     sh_alu,
  input  logic [DATA_W-1:0]    sh_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err
`ifdef SHIFT_ISSUE_STAT_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [15:0]          stat_err
`endif
);

  dec_t dec_c;
  logic accept_c, adv1_c, adv2_c;
  logic unused_rs_hi;

  logic               v1_q,   v1_d;
  logic [DATA_W-1:0]  a_q,    a_d;
  logic [SHAMT_W-1:0] b_q,    b_d;
  logic [ALU_W-1:0]   alu_q,  alu_d;
  logic [TAG_W-1:0]   tag1_q, tag1_d;
  logic               err1_q, err1_d;
  logic               v2_q,   v2_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [TAG_W-1:0]   otag_q, otag_d;
  logic               oerr_q, oerr_d;

  // Only the low bits of rs feed the amount mux.
  assign unused_rs_hi = ^in_rs[DATA_W-1:SHAMT_W];

  shift_decode u_dec (
    .funct_i  (in_funct),
    .shamt_i  (in_shamt),
    .rs_amt_i (in_rs[SHAMT_W-1:0]),
    .dec_c_o  (dec_c)
  );

  assign adv2_c   = v2_q & out_ready;
  assign adv1_c   = v1_q & (~v2_q | out_ready);
  assign in_ready = ~v1_q | adv1_c;
  assign accept_c = in_valid & in_ready;

  always_comb begin
    v1_d   = v1_q;
    a_d    = a_q;
    b_d    = b_q;
    alu_d  = alu_q;
    tag1_d = tag1_q;
    err1_d = err1_q;
    v2_d   = v2_q;
    data_d = data_q;
    otag_d = otag_q;
    oerr_d = oerr_q;

    if (accept_c) begin
      v1_d   = 1'b1;
      a_d    = in_rt;
      b_d    = dec_c.amt;
      alu_d  = dec_c.alu;
      tag1_d = in_tag;
      err1_d = dec_c.err;
    end else if (adv1_c) begin
      v1_d = 1'b0;
    end

    // Illegal ops carry a zero result regardless of what the shifter returns.
    if (adv1_c) begin
      v2_d   = 1'b1;
      data_d = err1_q ? '0 : sh_c;
      otag_d = tag1_q;
      oerr_d = err1_q;
    end else if (adv2_c) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      alu_q  <= '0;
      tag1_q <= '0;
      err1_q <= 1'b0;
      v2_q   <= 1'b0;
      data_q <= '0;
      otag_q <= '0;
      oerr_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      a_q    <= a_d;
      b_q    <= b_d;
      alu_q  <= alu_d;
      tag1_q <= tag1_d;
      err1_q <= err1_d;
      v2_q   <= v2_d;
      data_q <= data_d;
      otag_q <= otag_d;
      oerr_q <= oerr_d;
    end
  end

  assign sh_a      = a_q;
  assign sh_b      = b_q;
  assign sh_alu    = alu_q;
  assign out_valid = v2_q;
  assign out_data  = data_q;
  assign out_tag   = otag_q;
  assign out_err   = oerr_q;

`ifdef SHIFT_ISSUE_STAT_EN
  logic [31:0] ops_q;
  logic [15:0] errs_q;

  // Op count wraps; error count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q  <= '0;
      errs_q <= '0;
    end else if (adv2_c) begin
      ops_q <= ops_q + 32'd1;
      if (oerr_q && (errs_q != 16'hFFFF)) errs_q <= errs_q + 16'd1;
    end
  end

  assign stat_ops = ops_q;
  assign stat_err = errs_q;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench: queue-based reference model plus directed literal pins.
module tb_shift_issue_stage;

  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_funct;
  logic [31:0]       in_rt;
  logic [31:0]       in_rs;
  logic [4:0]        in_shamt;
  logic [TAG_W-1:0]  in_tag;
  logic [31:0]       sh_a;
  logic [4:0]        sh_b;
  logic [1:0]        sh_alu;
  logic [31:0]       sh_c;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
`ifdef SHIFT_ISSUE_STAT_EN
  logic [31:0]       stat_ops;
  logic [15:0]       stat_err;
`endif

  shift_issue_stage #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_funct  (in_funct),
    .in_rt     (in_rt),
    .in_rs     (in_rs),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .sh_alu    (sh_alu),
    .sh_c      (sh_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
`ifdef SHIFT_ISSUE_STAT_EN
    ,
    .stat_ops  (stat_ops),
    .stat_err  (stat_err)
`endif
  );

  always #5 clk = ~clk;

  // External barrel shifter stand-in.
  always_comb begin
    case (sh_alu)
      2'b11:   sh_c = sh_a << sh_b;
      2'b01:   sh_c = sh_a >> sh_b;
      2'b10:   sh_c = 32'($signed(sh_a) >>> sh_b);
      default: sh_c = sh_a;
    endcase
  end

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [1:0]       alu;
    logic [4:0]       amt;
    logic [31:0]      rt;
    int               acc;
  } item_t;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               cyc;
  } res_t;

  item_t q[$];
  res_t  log_q[$];
  res_t  seen;
  int    cyc, last_leave, total, bad;
  bit    just_rst, log_en;
  logic [31:0] m_ops;
  logic [15:0] m_errs;

  function automatic item_t expect_item(logic [5:0] f, logic [31:0] rt, logic [31:0] rs,
                                        logic [4:0] shamt, logic [TAG_W-1:0] tag);
    item_t it;
    int amt;
    it.tag = tag; it.rt = rt; it.err = 1'b0; it.acc = 0; amt = 0;
    case (f)
      6'd0: begin it.alu = 2'b11; amt = int'(shamt); end
      6'd2: begin it.alu = 2'b01; amt = int'(shamt); end
      6'd3: begin it.alu = 2'b10; amt = int'(shamt); end
      6'd4: begin it.alu = 2'b11; amt = int'(rs % 32); end
      6'd6: begin it.alu = 2'b01; amt = int'(rs % 32); end
      6'd7: begin it.alu = 2'b10; amt = int'(rs % 32); end
      default: begin it.alu = 2'b00; it.err = 1'b1; end
    endcase
    it.amt = 5'(amt);
    if (it.err)                  it.data = 32'd0;
    else if (f == 0 || f == 4)   it.data = rt << amt;
    else if (f == 2 || f == 6)   it.data = rt >> amt;
    else                         it.data = 32'($signed(rt) >>> amt);
    return it;
  endfunction

  // Head is presented once it has spent a cycle in flight and its predecessor has left.
  function automatic bit head_vis();
    int t;
    if (q.size() == 0) return 1'b0;
    t = q[0].acc + 1;
    if (last_leave > t) t = last_leave;
    return cyc >= t;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic model_update();
    bit rdy, hs, acc_now;
    item_t it;
    if (rst) begin
      q.delete();
      last_leave = 0;
      m_ops = '0;
      m_errs = '0;
      just_rst = 1'b1;
      cyc++;
      return;
    end
    just_rst = 1'b0;
    rdy = (q.size() < 2) || out_ready;
    hs = head_vis() && out_ready;
    acc_now = in_valid && rdy;
    cyc++;
    if (hs) begin
      if (log_en) log_q.push_back(seen);
      m_ops = m_ops + 32'd1;
      if (q[0].err && m_errs != 16'hFFFF) m_errs = m_errs + 16'd1;
      void'(q.pop_front());
      last_leave = cyc;
    end
    if (acc_now) begin
      it = expect_item(in_funct, in_rt, in_rs, in_shamt, in_tag);
      it.acc = cyc;
      q.push_back(it);
    end
  endtask

  task automatic compare();
    bit hv;
    int idx;
    hv = head_vis();
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
    chk("out_valid", 32'(out_valid), 32'(hv));
    if (hv) begin
      chk("out_data", out_data, q[0].data);
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
      chk("out_err", 32'(out_err), 32'(q[0].err));
      seen = '{data: out_data, tag: out_tag, err: out_err, cyc: cyc};
    end
    if (q.size() == 2 || (q.size() == 1 && !hv)) begin
      idx = q.size() - 1;
      chk("sh_a", sh_a, q[idx].rt);
      chk("sh_b", 32'(sh_b), 32'(q[idx].amt));
      chk("sh_alu", 32'(sh_alu), 32'(q[idx].alu));
    end
    if (just_rst) begin
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_sh_a", sh_a, 32'd0);
      chk("rst_sh_b", 32'(sh_b), 32'd0);
      chk("rst_sh_alu", 32'(sh_alu), 32'd0);
    end
`ifdef SHIFT_ISSUE_STAT_EN
    chk("stat_ops", stat_ops, m_ops);
    chk("stat_err", 32'(stat_err), 32'(m_errs));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send(logic [5:0] f, logic [31:0] rt, logic [31:0] rs, logic [4:0] sh,
                      logic [TAG_W-1:0] tg);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_funct = f; in_rt = rt; in_rs = rs; in_shamt = sh; in_tag = tg;
    for (int k = 0; k < 50 && !done; k++) begin
      done = (q.size() < 2) || out_ready;
      step();
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: got=not_accepted exp=accepted tag=%0d", tg);
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_log(string name, int i, logic [31:0] d, logic [TAG_W-1:0] t, logic e);
    res_t r;
    r = (i < log_q.size()) ? log_q[i] : '{data: 32'hDEADBEEF, tag: '1, err: 1'bx, cyc: 0};
    chk({name, "_data"}, r.data, d);
    chk({name, "_tag"}, 32'(r.tag), 32'(t));
    chk({name, "_err"}, 32'(r.err), 32'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit will_acc;
    int sel;
    logic [5:0] fsel;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_funct = '0; in_rt = '0; in_rs = '0; in_shamt = '0; in_tag = '0;
    cyc = 0; last_leave = 0; total = 0; bad = 0; just_rst = 1'b0; log_en = 1'b0;
    m_ops = '0; m_errs = '0;
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Directed functional cases with out_ready held high.
    log_en = 1'b1;
    send(6'd0, 32'h0000_00FE, 32'd0, 5'd2, 5'd1);
    chk("sll_sh_alu", 32'(sh_alu), 32'd3);
    chk("sll_sh_b", 32'(sh_b), 32'd2);
    idle(3);
    send(6'd2, 32'hAAAA_FFFF, 32'd0, 5'd2, 5'd2);
    send(6'd3, 32'hAAAA_FFFF, 32'd0, 5'd2, 5'd3);
    idle(4);
    send(6'd4, 32'h0000_0001, 32'h0000_0022, 5'd7, 5'd4);
    idle(3);
    send(6'h20, 32'h1234_5678, 32'd0, 5'd3, 5'd9);
    send(6'd3, 32'h8000_0000, 32'd0, 5'd4, 5'd10);
    idle(4);
    chk("log_size", 32'(log_q.size()), 32'd6);
    chk_log("sll", 0, 32'h0000_03F8, 5'd1, 1'b0);
    chk_log("srl", 1, 32'h2AAA_BFFF, 5'd2, 1'b0);
    chk_log("sra", 2, 32'hEAAA_BFFF, 5'd3, 1'b0);
    if (log_q.size() >= 3) chk("srl_sra_gap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd1);
    chk_log("sllv", 3, 32'h0000_0004, 5'd4, 1'b0);
    chk_log("illegal", 4, 32'h0000_0000, 5'd9, 1'b1);
    chk_log("sra_after_err", 5, 32'hF800_0000, 5'd10, 1'b0);

    // Back-pressure: two fill the pipe, the third waits until drain starts.
    log_q.delete();
    out_ready = 1'b0;
    send(6'd0, 32'd1, 32'd0, 5'd1, 5'd1);
    send(6'd0, 32'd1, 32'd0, 5'd2, 5'd2);
    in_valid = 1'b1; in_funct = 6'd0; in_rt = 32'd1; in_shamt = 5'd3; in_tag = 5'd3;
    idle(3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_data", out_data, 32'd2);
    chk("bp_hold_tag", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    send(6'd0, 32'd1, 32'd0, 5'd3, 5'd3);
    idle(4);
    chk_log("bp0", 0, 32'd2, 5'd1, 1'b0);
    chk_log("bp1", 1, 32'd4, 5'd2, 1'b0);
    chk_log("bp2", 2, 32'd8, 5'd3, 1'b0);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(6'd2, 32'hFFFF_0000, 32'd0, 5'd4, 5'd7);
    send(6'd7, 32'hFFFF_0000, 32'd5, 5'd0, 5'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
`ifdef SHIFT_ISSUE_STAT_EN
    chk("mid_rst_stat_ops", stat_ops, 32'd0);
`endif
    out_ready = 1'b1;
    idle(2);

    // Randomized traffic with back-pressure and occasional reset.
    log_en = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        continue;
      end
      if (!in_valid && $urandom_range(0, 9) < 7) begin
        sel = int'($urandom_range(0, 7));
        case (sel)
          0: fsel = 6'd0;
          1: fsel = 6'd2;
          2: fsel = 6'd3;
          3: fsel = 6'd4;
          4: fsel = 6'd6;
          5: fsel = 6'd7;
          default: fsel = 6'($urandom);
        endcase
        in_valid = 1'b1; in_funct = fsel; in_rt = $urandom; in_rs = $urandom;
        in_shamt = 5'($urandom); in_tag = TAG_W'($urandom);
      end
      will_acc = in_valid && ((q.size() < 2) || out_ready);
      step();
      if (will_acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk("drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
